// File: rtl/input_fifo.sv
// Router input-port flit buffer: circular FIFO with first-word-fall-through
// head, early ready for a registered-valid sender, and sticky overflow flag.
module input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_C =
    (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] RDY_MAX =
    (PTR_WIDTH+1)'(DEPTH - 2);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR =
    PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  wr;
  logic                  rd;

  function automatic logic [PTR_WIDTH-1:0] nxt(
    input logic [PTR_WIDTH-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  // two free slots: one flit may already be in flight
  assign ready_out = (count <= RDY_MAX);
  assign rd        = read_en && !empty;
  assign wr        = valid_in && (!full || rd);
  assign data_out  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr && !rst)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= nxt(wr_ptr);
      if (rd)
        rd_ptr <= nxt(rd_ptr);
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (valid_in && !wr)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_fifo.sv
// Directed plus random bench for input_fifo against a queue-based
// reference model of the flit buffer.
module tb_input_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [2:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;

  input_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .PTR_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .data_in(data_in),
    .ready_out(ready_out),
    .read_en(read_en),
    .data_out(data_out),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", DW'(count), DW'(n));
    chk("empty", DW'(empty), DW'(n == 0));
    chk("full", DW'(full), DW'(n == DEPTH));
    chk("ready", DW'(ready_out), DW'(n <= DEPTH - 2));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    if (n != 0)
      chk("data_out", data_out, q[0]);
  endtask

  // one clock: apply inputs, advance model at the edge, check after
  task automatic cycle(input logic r, input logic v,
                       input logic [DW-1:0] d,
                       input logic re);
    bit do_rd;
    bit do_wr;
    rst = r;
    valid_in = v;
    data_in = d;
    read_en = re;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      do_rd = re && (q.size() > 0);
      do_wr = v && ((q.size() < DEPTH) || do_rd);
      if (do_rd)
        void'(q.pop_front());
      if (do_wr)
        q.push_back(d);
      if (v && !do_wr)
        m_ovf = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    read_en = 1'b0;

    // reset and idle, pop while empty
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_ready", DW'(ready_out), 1);
    cycle(0, 0, 0, 1);
    chk("empty_pop", DW'(count), 0);

    // single flit
    cycle(0, 1, 32'hA5A5_0001, 0);
    chk("single", data_out, 32'hA5A5_0001);
    cycle(0, 0, 0, 1);
    chk("single_pop", DW'(empty), 1);

    // fill 1..4, drain, then refill 5..8 across the wrap
    for (int i = 1; i <= 4; i++)
      cycle(0, 1, DW'(i), 0);
    chk("fill_full", DW'(full), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", data_out, DW'(i));
      cycle(0, 0, 0, 1);
    end
    for (int i = 5; i <= 8; i++)
      cycle(0, 1, DW'(i), 0);

    // push and pop together while full
    cycle(0, 1, 32'd9, 1);
    chk("sim_cnt", DW'(count), 4);
    chk("sim_head", data_out, 32'd6);
    chk("sim_ovf", DW'(overflow), 0);

    // overflow is sticky
    cycle(0, 1, 32'hDEAD, 0);
    chk("ovf_set", DW'(overflow), 1);
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 0, 1);
    chk("ovf_sticky", DW'(overflow), 1);

    // reset mid-operation with a flit in flight
    for (int i = 0; i < 3; i++)
      cycle(0, 1, DW'(32'h10 + i), 0);
    cycle(1, 1, 32'hCC, 0);
    chk("rst_mid", DW'(count), 0);
    cycle(0, 1, 32'h0000_00BB, 0);
    chk("after_rst", data_out, 32'h0000_00BB);
    cycle(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 6,
            $urandom,
            $urandom_range(0, 1) == 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
